// File: rtl/shifter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shifter_pkg: op encodings, sizes and stage payload for the right shifter |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package shifter_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    OP_ROR = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    op_e              op;
    logic [CNT_W-1:0] ecnt;
    logic             sign;
    logic             valid;
  } stage_t;

  // A left rotate by n is a right rotate by (WIDTH - n) mod WIDTH.
  function automatic logic [CNT_W-1:0] eff_cnt(input op_e op, input logic [CNT_W-1:0] cnt);
    return (op == OP_ROL) ? (CNT_W'(0) - cnt) : cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_right_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shift_right_stage: one registered conditional right shift by SHAMT       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module shift_right_stage
  import shifter_pkg::*;
#(
  parameter int SHAMT = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   adv,
  input  stage_t in_stage,
  output stage_t out_stage
);

  localparam int BIT = $clog2(SHAMT);

  stage_t nxt;

  always_comb begin
    nxt = in_stage;
    if (in_stage.ecnt[BIT]) begin
      case (in_stage.op)
        OP_SRL:  nxt.data = {{SHAMT{1'b0}}, in_stage.data[WIDTH-1:SHAMT]};
        OP_SRA:  nxt.data = {{SHAMT{in_stage.sign}}, in_stage.data[WIDTH-1:SHAMT]};
        default: nxt.data = {in_stage.data[SHAMT-1:0], in_stage.data[WIDTH-1:SHAMT]};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_stage <= '0;
    end else if (adv) begin
      out_stage <= nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/shifter_right_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shifter_right_pipe: 4-stage pipelined 16-bit right shift/rotate unit.    |
// | Optional out_zero flag when SHIFT_ZERO_FLAG_EN is defined.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module shifter_right_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SHIFT_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);
  import shifter_pkg::*;

  logic         adv;
  stage_t       head;
  stage_t [4:0] st;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Stage 1 loads every advancing cycle; a missing transfer becomes a bubble.
  always_comb begin
    head       = '0;
    head.data  = in_data;
    head.op    = op_e'(in_op);
    head.ecnt  = eff_cnt(op_e'(in_op), in_cnt);
    head.sign  = in_data[WIDTH-1];
    head.valid = in_valid & adv;
  end

  assign st[0] = head;

  for (genvar k = 0; k < 4; k++) begin : g_stage
    shift_right_stage #(
      .SHAMT(1 << k)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (adv),
      .in_stage (st[k]),
      .out_stage(st[k+1])
    );
  end

  assign out_valid = st[4].valid;
  assign out_data  = st[4].data;

  logic unused_tail;
  assign unused_tail = ^{st[4].op, st[4].ecnt, st[4].sign};

`ifdef SHIFT_ZERO_FLAG_EN
  // Predicts whether the final shift-by-8 stage will produce zero.
  logic zero_next;

  always_comb begin
    zero_next = (st[3].data == '0);
    if (st[3].ecnt[3]) begin
      case (st[3].op)
        OP_SRL:  zero_next = (st[3].data[WIDTH-1:8] == '0);
        OP_SRA:  zero_next = (st[3].data[WIDTH-1:8] == '0) && !st[3].sign;
        default: zero_next = (st[3].data == '0);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_zero <= 1'b0;
    end else if (adv) begin
      out_zero <= st[3].valid & zero_next;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_shifter_right_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_shifter_right_pipe: scoreboard bench for the pipelined right shifter  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_shifter_right_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_cnt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
`ifdef SHIFT_ZERO_FLAG_EN
  logic        out_zero;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  shifter_right_pipe #(.WIDTH(16), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_cnt   (in_cnt),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef SHIFT_ZERO_FLAG_EN
    ,
    .out_zero (out_zero)
`endif
  );

  function automatic logic [15:0] model(input logic [15:0] a, input logic [3:0] n, input logic [1:0] op);
    logic [31:0] dbl;
    logic [31:0] tmp;
    dbl = {a, a};
    case (op)
      2'b00:   begin tmp = dbl >> n; model = tmp[15:0]; end
      2'b01:   model = a >> n;
      2'b10:   model = $signed(a) >>> n;
      default: begin tmp = dbl << n; model = tmp[31:16]; end
    endcase
  endfunction

  // Called just after a falling edge; records the expected result of an accept.
  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] c,
                       input logic [1:0] op, input logic ordy, input logic [15:0] e);
    in_valid  = v;
    in_data   = d;
    in_cnt    = c;
    in_op     = op;
    out_ready = ordy;
    #1;
    if (v && in_ready) exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 2'b00, 1'b0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency();
    int lat;
    logic [15:0] e;
    drive(1'b1, 16'h1234, 4'd4, 2'b00, 1'b1, 16'h4123);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      drive(1'b0, 16'h0, 4'h0, 2'b00, 1'b1, 16'h0);
    end while (!out_valid && lat < 10);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL latency: got %0d cycles want 4", lat); end
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    if (out_data !== e) begin errors++; $display("FAIL ror_1234_4: got %h want %h", out_data, e); end
    @(negedge clk);
  endtask

  task automatic test_vectors();
    localparam int NDIR = 8;
    logic [15:0] dd  [NDIR] = '{16'h8000, 16'h8000, 16'h8001, 16'hABCD, 16'hBEEF, 16'hBEEF, 16'h1234, 16'h7FFF};
    logic [3:0]  dc  [NDIR] = '{4'd15, 4'd15, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15};
    logic [1:0]  dop [NDIR] = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 2'b10};
    logic [15:0] de  [NDIR] = '{16'hFFFF, 16'h0001, 16'h0003, 16'hABCD, 16'hBEEF, 16'hBEEF, 16'h1234, 16'h0000};
    logic [15:0] d, e;
    logic [3:0]  c;
    logic [1:0]  op;
    int          guard;
    for (int i = 0; i < NDIR + 60; i++) begin
      if (i < NDIR) begin
        drive(1'b1, dd[i], dc[i], dop[i], 1'b1, de[i]);
      end else begin
        d  = 16'($urandom);
        c  = 4'($urandom_range(0, 15));
        op = 2'($urandom_range(0, 3));
        drive(1'($urandom_range(0, 1)), d, c, op, 1'($urandom_range(0, 1)), model(d, c, op));
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL vectors: got unexpected %h want none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin errors++; $display("FAIL vectors: got %h want %h", out_data, e); end
        end
      end
      @(negedge clk);
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 30) begin
      drive(1'b0, 16'h0, 4'h0, 2'b00, 1'b1, 16'h0);
      if (out_valid) begin
        checks++;
        e = exp_q.pop_front();
        if (out_data !== e) begin errors++; $display("FAIL vectors_drain: got %h want %h", out_data, e); end
      end
      @(negedge clk);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL vectors_lost: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  bc [3] = '{4'd4, 4'd8, 4'd8};
    logic [1:0]  bo [3] = '{2'b01, 2'b01, 2'b00};
    logic [15:0] be [3] = '{16'h000F, 16'h0000, 16'hF000};
    int          seen [3];
    int          n;
    logic [15:0] e;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 3) drive(1'b1, 16'h00F0, bc[i], bo[i], 1'b1, be[i]);
      else       drive(1'b0, 16'h0, 4'h0, 2'b00, 1'b1, 16'h0);
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0 || n >= 3) begin
          errors++; $display("FAIL b2b_extra: got %h want none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin errors++; $display("FAIL b2b_data: got %h want %h", out_data, e); end
          seen[n] = i;
          n++;
        end
      end
      @(negedge clk);
    end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL b2b_count: got %0d want 3", n);
    end else begin
      checks++;
      if (seen[0] != 4 || seen[1] != 5 || seen[2] != 6)
        begin errors++; $display("FAIL b2b_timing: got %0d,%0d,%0d want 4,5,6", seen[0], seen[1], seen[2]); end
    end
  endtask

  task automatic test_stall();
    logic [15:0] d, e, held;
    logic [3:0]  c;
    int          pops, guard;
    for (int i = 0; i < 4; i++) begin
      d = 16'($urandom);
      c = 4'($urandom_range(0, 15));
      drive(1'b1, d, c, 2'b10, 1'b1, model(d, c, 2'b10));
      @(negedge clk);
    end
    held = out_data;
    for (int s = 0; s < 3; s++) begin
      drive(1'b1, 16'hFFFF, 4'd3, 2'b00, 1'b0, model(16'hFFFF, 4'd3, 2'b00));
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
      checks++;
      if (out_valid !== 1'b1 || out_data !== held)
        begin errors++; $display("FAIL stall_hold: got %b/%h want 1/%h", out_valid, out_data, held); end
      @(negedge clk);
    end
    pops = 0;
    guard = 0;
    while (guard < 20) begin
      drive(1'b0, 16'h0, 4'h0, 2'b00, 1'b1, 16'h0);
      if (out_valid) begin
        checks++;
        pops++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stall_dup: got %h want none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin errors++; $display("FAIL stall_order: got %h want %h", out_data, e); end
        end
      end
      @(negedge clk);
      guard++;
    end
    checks++;
    if (pops != 4) begin errors++; $display("FAIL stall_count: got %0d want 4", pops); end
  endtask

  task automatic test_reset_mid();
    int          bad, lat;
    logic [15:0] e;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h1000 + 16'(i), 4'd1, 2'b01, 1'b0, model(16'h1000 + 16'(i), 4'd1, 2'b01));
      @(negedge clk);
    end
    drive(1'b0, 16'h0, 4'h0, 2'b00, 1'b0, 16'h0);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0)
      begin errors++; $display("FAIL rstmid_async: got %b/%h want 0/0000", out_valid, out_data); end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 16'h0, 4'h0, 2'b00, 1'b1, 16'h0);
      if (out_valid) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rstmid_ghost: got %0d outputs want 0", bad); end
    drive(1'b1, 16'h0F0F, 4'd4, 2'b00, 1'b1, 16'hF0F0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      drive(1'b0, 16'h0, 4'h0, 2'b00, 1'b1, 16'h0);
    end while (!out_valid && lat < 10);
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    if (!out_valid || out_data !== e)
      begin errors++; $display("FAIL rstmid_new: got %b/%h want 1/%h", out_valid, out_data, e); end
    @(negedge clk);
  endtask

`ifdef SHIFT_ZERO_FLAG_EN
  task automatic test_zero_flag();
    logic [15:0] zd [2] = '{16'h0001, 16'h8000};
    logic        zf [2] = '{1'b1, 1'b0};
    logic [15:0] e;
    int          n;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 2) drive(1'b1, zd[i], 4'd1, 2'b01, 1'b1, model(zd[i], 4'd1, 2'b01));
      else       drive(1'b0, 16'h0, 4'h0, 2'b00, 1'b1, 16'h0);
      checks++;
      if (!out_valid && out_zero !== 1'b0) begin errors++; $display("FAIL zero_idle: got %b want 0", out_zero); end
      if (out_valid && n < 2) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        if (out_data !== e || out_zero !== zf[n])
          begin errors++; $display("FAIL zero_flag: got %h/%b want %h/%b", out_data, out_zero, e, zf[n]); end
        n++;
      end
      @(negedge clk);
    end
    checks++;
    if (n != 2) begin errors++; $display("FAIL zero_count: got %0d want 2", n); end
  endtask
`endif

  initial begin
    in_valid  = 1'b0;
    in_data   = 16'h0;
    in_cnt    = 4'h0;
    in_op     = 2'b00;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef SHIFT_ZERO_FLAG_EN
    test_zero_flag();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
